// File: rtl/cnt_seg_scan.sv
// Two-digit multiplexed 7-segment display for a 4-bit counter (0..15).
// Also produces a 15->0 wrap pulse and shows wrap parity on the ones-digit dp.
module cnt_seg_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cnt_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       wrap_pulse,
  output logic [3:0] cnt_q
);

  localparam int             PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic           DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic [1:0]     AN_OFF    = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

  typedef enum logic {DIG_ONES = 1'b0, DIG_TENS = 1'b1} dig_e;

  dig_e          dsel_q, dsel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    cnt_d;
  logic          wrap_q, wrap_d;
  logic          par_q, par_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [1:0]    an_q, an_d;

  logic          tens;
  logic [3:0]    ones;
  logic [6:0]    seg_raw;
  logic [1:0]    an_on;
  logic          dp_lit;

  // Active-high {g,f,e,d,c,b,a}; anything outside 0..9 is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    cnt_d   = cnt_in;
    wrap_d  = (cnt_q == 4'd15) && (cnt_in == 4'd0);
    par_d   = par_q ^ wrap_q;

    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    dsel_d  = dsel_q;
    if (presc_q == PRESC_MAX)
      dsel_d = (dsel_q == DIG_ONES) ? DIG_TENS : DIG_ONES;

    tens = (cnt_q >= 4'd10);
    ones = tens ? cnt_q - 4'd10 : cnt_q;

    // Output register follows the digit selected before this edge.
    seg_raw = 7'b0000000;
    an_on   = 2'b01;
    dp_lit  = 1'b0;
    if (dsel_q == DIG_TENS) begin
      an_on   = 2'b10;
      seg_raw = tens ? seg7(4'd1) : 7'b0000000;
    end else begin
      seg_raw = seg7(ones);
      dp_lit  = par_q;
    end

    seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d  = AN_ACTIVE_LOW  ? ~an_on   : an_on;
    dp_d  = dp_lit ^ SEG_ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      wrap_q  <= 1'b0;
      par_q   <= 1'b0;
      presc_q <= '0;
      dsel_q  <= DIG_ONES;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      an_q    <= AN_OFF;
    end else begin
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      par_q   <= par_d;
      presc_q <= presc_d;
      dsel_q  <= dsel_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_cnt_seg_scan.sv
// Directed-vector bench for cnt_seg_scan (SCAN_DIV=4, active-low pins).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_cnt_seg_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cnt_in;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       wrap_pulse;
  logic [3:0] cnt_q;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       wp;
    logic [3:0] cq;
  } exp_t;

  exp_t exp_q[$];
  int   step_no = 0;

  always #5 clk = ~clk;

  cnt_seg_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .seg(seg), .dp(dp),
    .an(an), .wrap_pulse(wrap_pulse), .cnt_q(cnt_q)
  );

  // a = enabled digits (bit0 ones), s = lit segments, d = dp lit; all active-high here.
  task automatic step(input logic r, input logic [3:0] c, input logic [1:0] a,
                      input logic [6:0] s, input logic d, input logic w, input logic [3:0] q);
    exp_t e;
    rst_n  = r;
    cnt_in = c;
    @(posedge clk);
    #1;
    e.an  = ~a;
    e.seg = ~s;
    e.dp  = ~d;
    e.wp  = w;
    e.cq  = q;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input int n, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step %0d: got %b expected %b", name, n, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n++;
        cmp("an",         n, {5'b0, an},         {5'b0, e.an});
        cmp("seg",        n, seg,                e.seg);
        cmp("dp",         n, {6'b0, dp},         {6'b0, e.dp});
        cmp("wrap_pulse", n, {6'b0, wrap_pulse}, {6'b0, e.wp});
        cmp("cnt_q",      n, {3'b0, cnt_q},      {3'b0, e.cq});
      end
    end
  end

  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S3 = 7'b1001111,
                         S4 = 7'b1100110, S5 = 7'b1101101, S7 = 7'b0000111,
                         BL = 7'b0000000;

  initial begin : stim
    // reset held 3 cycles with cnt_in=9: everything inactive
    step(0, 9, 2'b00, BL, 0, 0, 0);
    step(0, 9, 2'b00, BL, 0, 0, 0);
    step(0, 9, 2'b00, BL, 0, 0, 0);
    // 13: ones phase shows 3, tens phase shows 1, 4 cycles each
    step(1, 13, 2'b01, S0, 0, 0, 13);
    step(1, 13, 2'b01, S3, 0, 0, 13);
    step(1, 13, 2'b01, S3, 0, 0, 13);
    step(1, 13, 2'b01, S3, 0, 0, 13);
    step(1, 13, 2'b10, S1, 0, 0, 13);
    step(1, 13, 2'b10, S1, 0, 0, 13);
    step(1, 13, 2'b10, S1, 0, 0, 13);
    step(1, 13, 2'b10, S1, 0, 0, 13);
    // 7: ones shows 7, tens blanked
    step(1, 7, 2'b01, S3, 0, 0, 7);
    step(1, 7, 2'b01, S7, 0, 0, 7);
    step(1, 7, 2'b01, S7, 0, 0, 7);
    step(1, 7, 2'b01, S7, 0, 0, 7);
    step(1, 7, 2'b10, BL, 0, 0, 7);
    step(1, 7, 2'b10, BL, 0, 0, 7);
    step(1, 7, 2'b10, BL, 0, 0, 7);
    step(1, 7, 2'b10, BL, 0, 0, 7);
    // wrap 14,15,0,1: pulse when cnt_q first reads 0
    step(1, 14, 2'b01, S7, 0, 0, 14);
    step(1, 15, 2'b01, S4, 0, 0, 15);
    step(1, 0,  2'b01, S5, 0, 1, 0);
    step(1, 1,  2'b01, S0, 0, 0, 1);
    // parity now 1, but tens dp stays unlit
    step(1, 1, 2'b10, BL, 0, 0, 1);
    step(1, 1, 2'b10, BL, 0, 0, 1);
    step(1, 1, 2'b10, BL, 0, 0, 1);
    step(1, 1, 2'b10, BL, 0, 0, 1);
    // ones dp lit; latency 3->5 shows two edges after the change
    step(1, 3, 2'b01, S1, 1, 0, 3);
    step(1, 5, 2'b01, S3, 1, 0, 5);
    step(1, 5, 2'b01, S5, 1, 0, 5);
    step(1, 5, 2'b01, S5, 1, 0, 5);
    // second wrap during tens phase clears parity
    step(1, 15, 2'b10, BL, 0, 0, 15);
    step(1, 0,  2'b10, S1, 0, 1, 0);
    step(1, 0,  2'b10, BL, 0, 0, 0);
    step(1, 7,  2'b10, BL, 0, 0, 7);
    // 7->0 jump: no pulse, dp unlit
    step(1, 0, 2'b01, S7, 0, 0, 0);
    step(1, 0, 2'b01, S0, 0, 0, 0);
    // third wrap coincides with a digit toggle, parity back to 1
    step(1, 15, 2'b01, S0, 0, 0, 15);
    step(1, 0,  2'b01, S5, 0, 1, 0);
    step(1, 0,  2'b10, BL, 0, 0, 0);
    step(1, 0,  2'b10, BL, 0, 0, 0);
    // mid-phase reset with parity=1
    step(0, 9, 2'b00, BL, 0, 0, 0);
    // restart: full ones period, dp unlit proves parity cleared
    step(1, 0, 2'b01, S0, 0, 0, 0);
    step(1, 0, 2'b01, S0, 0, 0, 0);
    step(1, 0, 2'b01, S0, 0, 0, 0);
    step(1, 0, 2'b01, S0, 0, 0, 0);
    step(1, 0, 2'b10, BL, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations unconsumed, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
